spi_upcount_master_top: RTL and testbench

Top level of the SPI up-counter master. It generates a periodic tick and runs a 14-bit decimal up-counter under a run/stop/clear control FSM driven by two button pulses. Every new counter value is shipped to a slave device over a 4-wire SPI link (mode 0, master only). Debug copies of the counter, run status and tick are exposed for board LEDs and simulation.

---
 rtl/spi_upcount_master_top.sv | 179 +++++++++++++++++
 tb/tb_spi_upcount_master_top.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_upcount_master_top.sv
// SPI up-counter master: tick generator, run/stop/clear FSM, 0..9999 counter, SPI mode-0 frame sender.
// Latency: button edge -> state 3 clocks, status 4 clocks; counter change -> ss low 2 clocks.
// Backpressure: none; counter changes during a busy frame collapse into one pending frame of the latest value.
module spi_upcount_master_top #(
   parameter int TICK_PERIOD_MS = 100,
   parameter int CLK_PER_MS     = 100_000,
   parameter int SCLK_DIV       = 50
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_runstop,
   input  logic        i_clear,
   output logic        sclk,
   output logic        mosi,
   input  logic        miso,
   output logic        ss,
   output logic [13:0] o_counter,
   output logic        o_runstop_status,
   output logic        o_tick
);
   localparam int TICK_N = TICK_PERIOD_MS * CLK_PER_MS;
   localparam int TW     = (TICK_N > 1) ? $clog2(TICK_N) : 1;
   localparam int DW     = $clog2(2 * SCLK_DIV + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_N - 1);
   localparam logic [DW-1:0] HALF_LAST = DW'(SCLK_DIV - 1);
   localparam logic [DW-1:0] GAP_LAST  = DW'(2 * SCLK_DIV - 1);

   typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_CLEAR} ctrl_state_t;
   typedef enum logic [1:0] {SP_IDLE, SP_XFER, SP_GAP} spi_state_t;

   logic unused_miso;
   assign unused_miso = miso;

   // Buttons are not debounced: a single-cycle pulse must still yield one event.
   logic [1:0] rs_sync, clr_sync;
   logic       rs_d, clr_d;
   logic       rs_ev, clr_ev;

   always_ff @(posedge clk) begin
      if (reset) begin
         rs_sync  <= '0;
         clr_sync <= '0;
         rs_d     <= 1'b0;
         clr_d    <= 1'b0;
      end else begin
         rs_sync  <= {rs_sync[0], i_runstop};
         clr_sync <= {clr_sync[0], i_clear};
         rs_d     <= rs_sync[1];
         clr_d    <= clr_sync[1];
      end
   end

   assign rs_ev  = rs_sync[1] & ~rs_d;
   assign clr_ev = clr_sync[1] & ~clr_d;

   logic [TW-1:0] tick_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt <= '0;
         o_tick   <= 1'b0;
      end else if (tick_cnt == TICK_LAST) begin
         tick_cnt <= '0;
         o_tick   <= 1'b1;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
         o_tick   <= 1'b0;
      end
   end

   ctrl_state_t state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= ST_STOP;
         o_runstop_status <= 1'b0;
      end else begin
         o_runstop_status <= (state == ST_RUN);
         case (state)
            ST_STOP: begin
               if (clr_ev)     state <= ST_CLEAR;
               else if (rs_ev) state <= ST_RUN;
            end
            ST_RUN: begin
               if (clr_ev)     state <= ST_CLEAR;
               else if (rs_ev) state <= ST_STOP;
            end
            default: state <= ST_STOP;
         endcase
      end
   end

   logic [13:0] counter_nxt;
   logic        cnt_upd;

   always_comb begin
      counter_nxt = o_counter;
      if (state == ST_CLEAR)
         counter_nxt = '0;
      else if (state == ST_RUN && o_tick)
         counter_nxt = (o_counter == 14'd9999) ? 14'd0 : o_counter + 14'd1;
   end

   // cnt_upd marks the cycle in which o_counter already holds the new value.
   always_ff @(posedge clk) begin
      if (reset) begin
         o_counter <= '0;
         cnt_upd   <= 1'b0;
      end else begin
         o_counter <= counter_nxt;
         cnt_upd   <= (counter_nxt != o_counter);
      end
   end

   spi_state_t    spi_state;
   logic [DW-1:0] div_cnt;
   logic [3:0]    bit_cnt;
   logic [15:0]   shreg;
   logic          pend;

   always_ff @(posedge clk) begin
      if (reset) begin
         spi_state <= SP_IDLE;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         pend      <= 1'b0;
         sclk      <= 1'b0;
         mosi      <= 1'b0;
         ss        <= 1'b1;
      end else begin
         if (cnt_upd) pend <= 1'b1;
         case (spi_state)
            SP_IDLE: begin
               if (cnt_upd || pend) begin
                  // Frame MSB is the zero pad, so mosi starts low.
                  shreg     <= {2'b00, o_counter};
                  mosi      <= 1'b0;
                  ss        <= 1'b0;
                  sclk      <= 1'b0;
                  div_cnt   <= '0;
                  bit_cnt   <= '0;
                  pend      <= 1'b0;
                  spi_state <= SP_XFER;
               end
            end
            SP_XFER: begin
               if (div_cnt == HALF_LAST) begin
                  div_cnt <= '0;
                  if (!sclk) begin
                     sclk <= 1'b1;
                  end else if (bit_cnt == 4'd15) begin
                     sclk      <= 1'b0;
                     ss        <= 1'b1;
                     mosi      <= 1'b0;
                     spi_state <= SP_GAP;
                  end else begin
                     sclk    <= 1'b0;
                     shreg   <= {shreg[14:0], 1'b0};
                     mosi    <= shreg[14];
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            SP_GAP: begin
               if (div_cnt == GAP_LAST) begin
                  div_cnt   <= '0;
                  spi_state <= SP_IDLE;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            default: spi_state <= SP_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_upcount_master_top.sv
// Directed bench for spi_upcount_master_top with a shortened tick (4 clocks) and fast SCLK.
module tb_spi_upcount_master_top;
   localparam int TPM = 1;
   localparam int CPM = 4;
   localparam int SD  = 2;
   localparam int N   = TPM * CPM;

   logic        clk, reset, i_runstop, i_clear, miso;
   logic        sclk, mosi, ss, o_runstop_status, o_tick;
   logic [13:0] o_counter;

   int vectors = 0;
   int miscompares = 0;

   spi_upcount_master_top #(.TICK_PERIOD_MS(TPM), .CLK_PER_MS(CPM), .SCLK_DIV(SD)) dut (
      .clk(clk), .reset(reset), .i_runstop(i_runstop), .i_clear(i_clear),
      .sclk(sclk), .mosi(mosi), .miso(miso), .ss(ss),
      .o_counter(o_counter), .o_runstop_status(o_runstop_status), .o_tick(o_tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // SPI frame monitor: decodes mosi on rising sclk while ss is low.
   int          m_low, m_gap, m_bits, m_first, m_frames, m_min_gap;
   int          last_low, last_bits, last_first;
   logic [15:0] m_shreg, last_frame;
   logic        ss_prev, sclk_prev;

   initial begin
      m_low = 0; m_gap = 0; m_bits = 0; m_first = 0; m_frames = 0; m_min_gap = 1000000;
      last_low = 0; last_bits = 0; last_first = 0; m_shreg = '0; last_frame = '0;
      ss_prev = 1'b1; sclk_prev = 1'b0;
   end

   always @(negedge clk) begin
      if (reset) begin
         ss_prev = 1'b1;
         sclk_prev = 1'b0;
         m_gap = 0;
      end else begin
         if (!ss) begin
            if (ss_prev) begin
               if (m_frames > 0 && m_gap < m_min_gap) m_min_gap = m_gap;
               m_low = 1; m_bits = 0; m_first = 0; m_shreg = '0;
            end else begin
               m_low++;
            end
            if (sclk && !sclk_prev) begin
               if (m_bits == 0) m_first = m_low - 1;
               m_bits++;
               m_shreg = {m_shreg[14:0], mosi};
            end
         end else if (!ss_prev) begin
            last_frame = m_shreg; last_bits = m_bits; last_low = m_low; last_first = m_first;
            m_frames++;
            m_gap = 1;
         end else begin
            m_gap++;
         end
         ss_prev = ss;
         sclk_prev = sclk;
      end
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_tick(input string tag, output int cnt);
      bit seen;
      seen = 1'b0;
      cnt = -1;
      for (int i = 0; i < 2 * N + 2 && !seen; i++) begin
         @(negedge clk);
         if (o_tick) begin
            seen = 1'b1;
            cnt = int'(o_counter);
         end
      end
      check({tag, "_tick_seen"}, longint'(seen), 1);
   endtask

   task automatic wait_status(input string tag, input logic exp, input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge clk);
         if (o_runstop_status === exp) seen = 1'b1;
      end
      check(tag, longint'(seen), 1);
   endtask

   task automatic wait_counter(input string tag, input int exp, input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge clk);
         if (int'(o_counter) == exp) seen = 1'b1;
      end
      check(tag, longint'(seen), 1);
   endtask

   // Called #1 after a clock edge; holds the buttons high for exactly one clock.
   task automatic pulse(input logic rs, input logic cl);
      i_runstop = rs;
      i_clear = cl;
      @(posedge clk);
      #1;
      i_runstop = 1'b0;
      i_clear = 1'b0;
   endtask

   // Pressed one clock after a tick so RUN is reached just after the next tick.
   task automatic start_run(input string tag);
      int c;
      wait_tick({tag, "_sync"}, c);
      @(posedge clk);
      @(posedge clk);
      #1;
      pulse(1'b1, 1'b0);
      wait_status({tag, "_status_on"}, 1'b1, 10);
   endtask

   initial begin
      int c, n;
      bit found;
      longint t0, t1;

      reset = 1'b1; i_runstop = 1'b0; i_clear = 1'b0; miso = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_counter", o_counter, 0);
      check("rst_status", o_runstop_status, 0);
      check("rst_tick", o_tick, 0);
      check("rst_sclk", sclk, 0);
      check("rst_mosi", mosi, 0);
      check("rst_ss", ss, 1);
      @(posedge clk);
      #1 reset = 1'b0;

      // Run for ten ticks, then stop on the tick edge that reaches 10.
      start_run("run1");
      for (int k = 0; k < 10; k++) begin
         wait_tick("run1", c);
         check("run1_tick_value", c, k);
      end
      @(posedge clk);
      #1;
      check("run1_after", o_counter, 10);
      pulse(1'b1, 1'b0);
      wait_status("stop1_status_off", 1'b0, 10);

      n = 0;
      repeat (5 * N) begin
         @(negedge clk);
         if (o_tick) n++;
      end
      check("stopped_tick_count", n, 5);
      check("stopped_hold", o_counter, 10);

      @(posedge clk);
      #1;
      pulse(1'b0, 1'b1);
      wait_counter("clear1_zero", 0, 5);
      check("clear1_status", o_runstop_status, 0);
      for (int k = 0; k < 2; k++) begin
         wait_tick("clear1_hold", c);
         check("clear1_hold_value", c, 0);
      end
      check("clear1_back_to_stop", o_runstop_status, 0);

      start_run("run2");
      for (int k = 0; k < 5; k++) begin
         wait_tick("run2", c);
         check("run2_tick_value", c, k);
      end
      @(posedge clk);
      #1;
      check("run2_after", o_counter, 5);
      pulse(1'b1, 1'b0);
      wait_status("stop2_status_off", 1'b0, 10);

      wait_tick("period_a", c);
      t0 = longint'($time);
      wait_tick("period_b", c);
      t1 = longint'($time);
      check("tick_period_time", t1 - t0, longint'(N) * 10);

      // Counter is frozen at 5; the last frame must carry it.
      repeat (250) @(negedge clk);
      check("spi_frames_seen", longint'(m_frames > 0), 1);
      check("spi_last_data", last_frame, 16'h0005);
      check("spi_last_bits", last_bits, 16);
      check("spi_ss_low_clocks", last_low, 32 * SD);
      check("spi_first_rise", last_first, SD);
      check("spi_min_gap_ok", longint'(m_min_gap >= 2 * SD), 1);
      check("spi_idle_ss", ss, 1);
      check("spi_idle_sclk", sclk, 0);

      start_run("run3");
      found = 1'b0;
      for (int i = 0; i < 10000 && !found; i++) begin
         wait_tick("run3", c);
         if (c == 9999) found = 1'b1;
      end
      check("wrap_reached_9999", longint'(found), 1);
      @(posedge clk);
      #1;
      check("wrap_to_zero", o_counter, 0);
      for (int k = 0; k < 3; k++) begin
         wait_tick("post_wrap", c);
         check("post_wrap_value", c, k);
      end
      @(posedge clk);
      #1;
      check("before_both", o_counter, 3);
      pulse(1'b1, 1'b1);
      wait_counter("both_zero", 0, 5);
      wait_status("both_status_off", 1'b0, 10);
      for (int k = 0; k < 2; k++) begin
         wait_tick("both_hold", c);
         check("both_hold_value", c, 0);
      end
      check("both_stop_state", o_runstop_status, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
